// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
// The cache attaches through the slave modport; fetch stage and memory drive the master side.
interface icache_dm_if;
    logic        cache_req;
    logic [31:0] addr_inst;
    logic        cache_ready;
    logic        cache_valid;
    logic [63:0] cache_rdata;
    logic        fence_i;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_rlast;

    modport slave (
        input  cache_req, addr_inst, fence_i,
        input  mem_ready, mem_rvalid, mem_rdata, mem_rlast,
        output cache_ready, cache_valid, cache_rdata,
        output mem_req, mem_addr
    );

    modport master (
        output cache_req, addr_inst, fence_i,
        output mem_ready, mem_rvalid, mem_rdata, mem_rlast,
        input  cache_ready, cache_valid, cache_rdata,
        input  mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, 16-byte lines of two doublewords, two-beat refill.
// A fence_i arriving mid-access is deferred and applied on the first IDLE cycle.
module icache_dm #(
    parameter int NLINE      = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    icache_dm_if.slave bus
);
    localparam int IDXW = $clog2(NLINE);
    localparam int OFFW = $clog2(LINE_BYTES);
    localparam int TAGW = 32 - OFFW - IDXW;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_e;

    state_e           state_q, state_d;
    logic [31:3]      addr_q, addr_d;
    logic [NLINE-1:0] valid_q, valid_d;
    logic             fence_pend_q, fence_pend_d;
    logic             beat_q, beat_d;
    logic [1:0][63:0] rbuf_q, rbuf_d;

    logic [TAGW-1:0]  tag_q  [NLINE];
    logic [1:0][63:0] data_q [NLINE];

    logic [IDXW-1:0]  idx;
    logic [TAGW-1:0]  tag;
    logic             hit;
    logic             fence_req;
    logic             line_we;
    logic             unused_addr_lsb;

    assign idx             = addr_q[OFFW +: IDXW];
    assign tag             = addr_q[31 -: TAGW];
    assign hit             = valid_q[idx] && (tag_q[idx] == tag);
    assign fence_req       = fence_pend_q || bus.fence_i;
    assign unused_addr_lsb = ^bus.addr_inst[2:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        fence_pend_d = fence_pend_q || bus.fence_i;
        beat_d       = beat_q;
        rbuf_d       = rbuf_q;
        line_we      = 1'b0;

        bus.cache_ready = 1'b0;
        bus.cache_valid = 1'b0;
        bus.cache_rdata = (state_q == RESP) ? rbuf_q[addr_q[3]] : data_q[idx][addr_q[3]];
        bus.mem_req     = 1'b0;
        bus.mem_addr    = {addr_q[31:4], 4'b0000};

        unique case (state_q)
            IDLE: begin
                if (fence_req) begin
                    valid_d      = '0;
                    fence_pend_d = 1'b0;
                end else begin
                    bus.cache_ready = 1'b1;
                    if (bus.cache_req) begin
                        addr_d  = bus.addr_inst[31:3];
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (hit) begin
                    bus.cache_valid = 1'b1;
                    bus.cache_ready = !fence_req;
                    if (bus.cache_req && !fence_req) begin
                        addr_d = bus.addr_inst[31:3];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    beat_d  = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_rvalid) begin
                    rbuf_d[beat_q] = bus.mem_rdata;
                    beat_d         = !beat_q;
                    if (bus.mem_rlast) begin
                        // A fence on this beat still sets the pending flag, so the new line dies too.
                        line_we      = 1'b1;
                        valid_d[idx] = 1'b1;
                        beat_d       = 1'b0;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                bus.cache_valid = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            fence_pend_q <= 1'b0;
            beat_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fence_pend_q <= fence_pend_d;
            beat_q       <= beat_d;
        end
    end

    // NOTE: address latch, refill buffer and line arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        rbuf_q <= rbuf_d;
        if (line_we && !rst) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= rbuf_d;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm: acts as fetch stage and refill memory, and predicts
// hits, responses and handshakes from a line-level model of cache contents.
module tb_icache_dm;
    localparam int NLINE = 16;
    localparam int IDXW  = $clog2(NLINE);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_dm_if bus_if ();

    icache_dm #(.NLINE(NLINE), .LINE_BYTES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid [NLINE];
    int unsigned m_tag   [NLINE];
    logic [63:0] m_data  [NLINE][2];

    logic [63:0] nxt_d0, nxt_d1;
    int          opt_stall;
    int          opt_fence_beat;
    bit          opt_rst;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 4) % NLINE);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> (4 + IDXW);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic [63:0] model_dw(input logic [31:0] a);
        return m_data[idx_of(a)][a[3]];
    endfunction

    task automatic model_clear();
        for (int n = 0; n < NLINE; n++) m_valid[n] = 1'b0;
    endtask

    task automatic reset_opts();
        opt_stall      = 0;
        opt_fence_beat = -1;
        opt_rst        = 1'b0;
        nxt_d0         = {$urandom, $urandom};
        nxt_d1         = {$urandom, $urandom};
    endtask

    // Entered at the negedge before the MISS_REQ cycle.
    task automatic refill(input logic [31:0] a);
        logic [31:0] line_a;
        logic [63:0] beat_d [2];
        bit          fenced;
        int          gap;
        line_a    = {a[31:4], 4'h0};
        beat_d[0] = nxt_d0;
        beat_d[1] = nxt_d1;
        fenced    = 1'b0;
        for (int i = 0; i < opt_stall; i++) begin
            @(negedge clk);
            bus_if.mem_ready = 1'b0;
            #1;
            check("stall_req", bus_if.mem_req, 1);
            check("stall_addr", bus_if.mem_addr, line_a);
            check("stall_rdy", bus_if.cache_ready, 0);
        end
        @(negedge clk);
        bus_if.mem_ready = 1'b1;
        #1;
        check("miss_req", bus_if.mem_req, 1);
        check("miss_addr", bus_if.mem_addr, line_a);
        for (int b = 0; b < 2; b++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus_if.mem_ready  = 1'b0;
                bus_if.mem_rvalid = 1'b0;
                bus_if.fence_i    = 1'b0;
                #1;
                check("refill_noreq", bus_if.mem_req, 0);
                check("refill_noval", bus_if.cache_valid, 0);
            end
            @(negedge clk);
            bus_if.mem_ready  = 1'b0;
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = beat_d[b];
            bus_if.mem_rlast  = (b == 1);
            bus_if.fence_i    = (opt_fence_beat == b);
            if (opt_fence_beat == b) fenced = 1'b1;
            #1;
            check("refill_rdy", bus_if.cache_ready, 0);
            if (opt_rst && b == 0) begin
                @(negedge clk);
                rst               = 1'b1;
                bus_if.mem_rvalid = 1'b0;
                bus_if.mem_rlast  = 1'b0;
                bus_if.fence_i    = 1'b0;
                @(negedge clk);
                rst               = 1'b0;
                bus_if.mem_rvalid = 1'b1;
                bus_if.mem_rdata  = ~beat_d[1];
                bus_if.mem_rlast  = 1'b1;
                #1;
                check("rst_noreq", bus_if.mem_req, 0);
                check("rst_noval", bus_if.cache_valid, 0);
                check("rst_rdy", bus_if.cache_ready, 1);
                @(negedge clk);
                bus_if.mem_rvalid = 1'b0;
                bus_if.mem_rlast  = 1'b0;
                #1;
                check("stray_noval", bus_if.cache_valid, 0);
                check("stray_noreq", bus_if.mem_req, 0);
                model_clear();
                reset_opts();
                return;
            end
        end
        @(negedge clk);
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rlast  = 1'b0;
        bus_if.fence_i    = 1'b0;
        #1;
        check("resp_val", bus_if.cache_valid, 1);
        check("resp_data", bus_if.cache_rdata, a[3] ? beat_d[1] : beat_d[0]);
        check("resp_rdy", bus_if.cache_ready, 0);
        m_valid[idx_of(a)]   = 1'b1;
        m_tag[idx_of(a)]     = tag_of(a);
        m_data[idx_of(a)][0] = beat_d[0];
        m_data[idx_of(a)][1] = beat_d[1];
        @(negedge clk);
        #1;
        check("post_resp_val", bus_if.cache_valid, 0);
        check("post_resp_rdy", bus_if.cache_ready, fenced ? 0 : 1);
        if (fenced) model_clear();
        reset_opts();
    endtask

    // One request, optionally followed back-to-back by a second one while the first hits.
    task automatic fetch(input logic [31:0] a0, input logic [31:0] a1, input bit two, output bit redo);
        logic [31:0] cur;
        bit          more;
        bit          done;
        cur  = a0;
        more = two;
        done = 1'b0;
        redo = 1'b0;
        @(negedge clk);
        bus_if.cache_req = 1'b1;
        bus_if.addr_inst = a0;
        #1;
        check("idle_rdy", bus_if.cache_ready, 1);
        check("idle_noval", bus_if.cache_valid, 0);
        check("idle_noreq", bus_if.mem_req, 0);
        while (!done) begin
            @(negedge clk);
            if (more && model_hit(cur)) begin
                bus_if.cache_req = 1'b1;
                bus_if.addr_inst = a1;
            end else begin
                bus_if.cache_req = 1'b0;
                bus_if.addr_inst = $urandom;
            end
            #1;
            if (model_hit(cur)) begin
                check("hit_val", bus_if.cache_valid, 1);
                check("hit_data", bus_if.cache_rdata, model_dw(cur));
                check("hit_rdy", bus_if.cache_ready, 1);
                check("hit_noreq", bus_if.mem_req, 0);
                if (more) begin
                    cur  = a1;
                    more = 1'b0;
                end else begin
                    done = 1'b1;
                end
            end else begin
                check("miss_noval", bus_if.cache_valid, 0);
                check("miss_rdy", bus_if.cache_ready, 0);
                check("miss_noreq", bus_if.mem_req, 0);
                refill(cur);
                redo = more;
                done = 1'b1;
            end
        end
        bus_if.cache_req = 1'b0;
    endtask

    task automatic req(input logic [31:0] a0, input logic [31:0] a1, input bit two);
        bit redo;
        fetch(a0, a1, two, redo);
        if (redo) fetch(a1, 32'h0, 1'b0, redo);
    endtask

    task automatic fence_idle();
        @(negedge clk);
        bus_if.fence_i   = 1'b1;
        bus_if.cache_req = 1'b1;
        bus_if.addr_inst = $urandom;
        #1;
        check("fence_rdy", bus_if.cache_ready, 0);
        @(negedge clk);
        bus_if.fence_i   = 1'b0;
        bus_if.cache_req = 1'b0;
        #1;
        check("fence_after_rdy", bus_if.cache_ready, 1);
        check("fence_after_val", bus_if.cache_valid, 0);
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a0, a1;
        bus_if.cache_req  = 1'b0;
        bus_if.addr_inst  = '0;
        bus_if.fence_i    = 1'b0;
        bus_if.mem_ready  = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = '0;
        bus_if.mem_rlast  = 1'b0;
        rst = 1'b1;
        model_clear();
        reset_opts();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rdy", bus_if.cache_ready, 1);
        check("reset_val", bus_if.cache_valid, 0);
        check("reset_req", bus_if.mem_req, 0);

        // Cold miss, then hits including a back-to-back pair.
        nxt_d0 = 64'h1111_2222_3333_4444;
        nxt_d1 = 64'h5555_6666_7777_8888;
        req(32'h8000_0000, 32'h0, 1'b0);
        req(32'h8000_0008, 32'h0, 1'b0);
        req(32'h8000_0000, 32'h8000_0004, 1'b1);

        // Conflict on index 0.
        req(32'h8000_0100, 32'h0, 1'b0);
        req(32'h8000_0000, 32'h0, 1'b0);

        // Fence during refill, then the same address must miss.
        opt_fence_beat = 0;
        req(32'h8000_0020, 32'h0, 1'b0);
        req(32'h8000_0020, 32'h0, 1'b0);
        req(32'h8000_0028, 32'h0, 1'b0);

        // Fence on the last beat kills the fresh line as well.
        opt_fence_beat = 1;
        req(32'h8000_0030, 32'h0, 1'b0);
        req(32'h8000_0030, 32'h0, 1'b0);

        // Memory stall.
        opt_stall = 5;
        req(32'h8000_0040, 32'h0, 1'b0);

        // Reset mid-refill.
        opt_rst = 1'b1;
        req(32'h8000_0080, 32'h0, 1'b0);
        req(32'h8000_0080, 32'h0, 1'b0);

        fence_idle();
        req(32'h8000_0040, 32'h0, 1'b0);

        for (int it = 0; it < 300; it++) begin
            a0 = 32'h8000_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
                 | $urandom_range(0, 15);
            a1 = 32'h8000_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
                 | $urandom_range(0, 15);
            opt_stall      = $urandom_range(0, 3);
            opt_fence_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
            opt_rst        = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 14) == 0) fence_idle();
            req(a0, a1, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
